// File: rtl/noc_pkg.sv
// Shared NoC types: flit format, flit labels and virtual-channel sizing.
package noc_pkg;

    localparam int VC_NUM_DEFAULT = 2;
    localparam int VC_SIZE        = $clog2(VC_NUM_DEFAULT);
    localparam int FLIT_DATA_W    = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t             flit_label;
        logic [VC_SIZE-1:0]      vc_id;
        logic [FLIT_DATA_W-1:0]  data;
    } flit_t;

    // HEAD and HEADTAIL both open a packet on an idle, claimed VC.
    function automatic logic is_head(input flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

endpackage

// File: rtl/vc_tx_state.sv
// Per-VC transmit bookkeeping: allocation (free) bit plus IDLE/ACTIVE packet FSM.
// Flags any protocol violation touching this VC in the current cycle.
module vc_tx_state
    import noc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_flit_tgt,
    input  flit_label_t i_flit_label,
    input  logic        i_on_off,
    input  logic        i_claim,
    input  logic        i_release,
    output logic        o_free,
    output logic        o_flit_ok,
    output logic        o_err
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } vc_state_t;

    vc_state_t r_state_reg;
    vc_state_t w_state_next;
    logic      r_free_reg;
    logic      w_free_next;
    logic      w_accept;
    logic      w_rel_err;
    logic      w_free_mid;

    // State and allocation bit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg <= ST_IDLE;
            r_free_reg  <= 1'b1;
        end else begin
            r_state_reg <= w_state_next;
            r_free_reg  <= w_free_next;
        end
    end

    // Legality of the offered flit, claim/release handling and FSM transitions.
    always_comb begin
        w_state_next = r_state_reg;
        w_free_next  = r_free_reg;
        o_flit_ok    = 1'b0;
        o_err        = 1'b0;
        w_accept     = 1'b0;
        w_rel_err    = 1'b0;
        w_free_mid   = r_free_reg;

        // A packet may only open on a claimed, idle VC; BODY/TAIL need an open packet.
        if (is_head(i_flit_label)) begin
            o_flit_ok = ~r_free_reg & (r_state_reg == ST_IDLE);
        end else begin
            o_flit_ok = (r_state_reg == ST_ACTIVE);
        end

        w_accept = i_valid & i_flit_tgt & i_on_off & o_flit_ok;

        // Release is applied before a same-cycle claim; releasing a free or busy VC is refused.
        w_rel_err  = i_release & (r_free_reg | (r_state_reg == ST_ACTIVE));
        w_free_mid = r_free_reg | (i_release & ~w_rel_err);
        w_free_next = w_free_mid & ~i_claim;

        o_err = (i_valid & i_flit_tgt & ~o_flit_ok)
              | w_rel_err
              | (i_claim & ~w_free_mid);

        if (w_accept) begin
            case (i_flit_label)
                HEAD:    w_state_next = ST_ACTIVE;
                TAIL:    w_state_next = ST_IDLE;
                default: w_state_next = r_state_reg;
            endcase
        end
    end

    assign o_free = r_free_reg;

endmodule

// File: rtl/output_link_tx.sv
// Output link transmitter: gates crossbar flits by downstream on/off and
// per-VC packet protocol, registers the link flit and a one-cycle error pulse.
module output_link_tx
    import noc_pkg::*;
#(
    parameter int VC_NUM = VC_NUM_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  flit_t             flit_i,
    output logic              ready_o,
    input  logic [VC_NUM-1:0] on_off_i,
    input  logic [VC_NUM-1:0] vc_claim_i,
    input  logic [VC_NUM-1:0] vc_release_i,
    output logic [VC_NUM-1:0] vc_free_o,
    output logic              valid_o,
    output flit_t             data_o,
    output logic              error_o
);

    logic [VC_NUM-1:0] w_tgt;
    logic [VC_NUM-1:0] w_flit_ok;
    logic [VC_NUM-1:0] w_vc_err;
    logic [VC_NUM-1:0] w_free;
    logic              w_claim_multi;
    logic              w_accept;

    logic              r_valid_reg;
    flit_t             r_data_reg;
    logic              r_error_reg;

    // More than one claim in a cycle is rejected as a whole.
    assign w_claim_multi = ($countones(vc_claim_i) > 1);

    generate
        for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc
            assign w_tgt[gi] = (flit_i.vc_id == VC_SIZE'(gi));

            vc_tx_state u_vc_tx_state (
                .clk          (clk),
                .rst          (rst),
                .i_valid      (valid_i),
                .i_flit_tgt   (w_tgt[gi]),
                .i_flit_label (flit_i.flit_label),
                .i_on_off     (on_off_i[gi]),
                .i_claim      (vc_claim_i[gi] & ~w_claim_multi),
                .i_release    (vc_release_i[gi]),
                .o_free       (w_free[gi]),
                .o_flit_ok    (w_flit_ok[gi]),
                .o_err        (w_vc_err[gi])
            );
        end
    endgenerate

    assign ready_o  = ~rst & (|(w_tgt & on_off_i & w_flit_ok));
    assign w_accept = valid_i & ready_o;

    // Link register: flit forwarded unmodified one cycle after acceptance, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_reg <= 1'b0;
            r_data_reg  <= '0;
            r_error_reg <= 1'b0;
        end else begin
            r_valid_reg <= w_accept;
            if (w_accept) begin
                r_data_reg <= flit_i;
            end
            r_error_reg <= (|w_vc_err) | w_claim_multi;
        end
    end

    assign valid_o   = r_valid_reg;
    assign data_o    = r_data_reg;
    assign error_o   = r_error_reg;
    assign vc_free_o = w_free;

endmodule

// File: doc/output_link_tx.md
OUTPUT_LINK_TX -- requirements
Module: output_link_tx

Interface
REQ-001 Parameter VC_NUM, default 2, number of virtual channels; VC_SIZE from noc_pkg equals $clog2(VC_NUM).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 valid_i  input  1  switch-allocated flit present on flit_i this cycle.
REQ-006 flit_i  input  flit_t  flit from crossbar; vc_id selects downstream VC.
REQ-007 ready_o  output  1  combinational; flit_i accepted this cycle when valid_i & ready_o.
REQ-008 on_off_i  input  VC_NUM  per-VC downstream buffer on/off; 1 = may send.
REQ-009 vc_claim_i  input  VC_NUM  one-hot pulse; VC allocator claims a downstream VC.
REQ-010 vc_release_i  input  VC_NUM  per-VC pulse; downstream VC allocatable again (tail left downstream buffer).
REQ-011 vc_free_o  output  VC_NUM  registered; 1 = downstream VC free for allocation.
REQ-012 valid_o  output  1  registered; flit on data_o valid on link.
REQ-013 data_o  output  flit_t  registered link flit.
REQ-014 error_o  output  1  registered; protocol violation seen in previous cycle.

Function
REQ-015 ready_o = on_off_i[flit_i.vc_id] & ~error condition for that flit (see REQ-019); independent of valid_i.
REQ-016 Accepted flit appears on data_o with valid_o=1 exactly one cycle later, unmodified; else valid_o=0 and data_o holds last value.
REQ-017 Per-VC packet FSM, states IDLE and ACTIVE: IDLE -> ACTIVE on accepted HEAD; ACTIVE -> IDLE on accepted TAIL; accepted HEADTAIL leaves state IDLE; BODY keeps ACTIVE.
REQ-018 A HEAD or HEADTAIL shall be accepted only if the VC is not free (claimed) and IDLE.
REQ-019 Violations: HEAD/HEADTAIL on ACTIVE VC, BODY/TAIL on IDLE VC, HEAD/HEADTAIL on free VC; flit with valid_i=1 is dropped (ready_o=0), FSM unchanged, error_o=1 next cycle.
REQ-020 valid_i while on_off_i[vc_id]=0: not accepted, no error; upstream holds flit.
REQ-021 vc_free_o[v]: cleared by vc_claim_i[v]; set by vc_release_i[v]; same-cycle claim and release on v: release applied first, then claim, result 0, no error.
REQ-022 vc_claim_i[v] while vc_free_o[v]=0 and no release on v: ignored, error_o=1 next cycle.
REQ-023 vc_release_i[v] while vc_free_o[v]=1 or VC v ACTIVE: ignored, error_o=1 next cycle.
REQ-024 vc_claim_i with more than one bit set: all claims ignored, error_o=1 next cycle.
REQ-025 error_o is a one-cycle pulse per violating cycle; no sticky state.

Reset
REQ-026 On rst: valid_o=0, data_o=0, error_o=0, vc_free_o all 1, every VC FSM IDLE.
REQ-027 rst mid-packet abandons it; no flit emitted the cycle after rst; inputs ignored while rst=1.

Structure
REQ-028 flit_t, flit_label_t (HEAD/BODY/TAIL/HEADTAIL), VC_SIZE and VC_NUM default belong in noc_pkg; no new package types.
REQ-029 One sub-module is natural: vc_tx_state, instantiated VC_NUM times, holding free bit and IDLE/ACTIVE FSM with error output; top ORs errors and registers data path.

Verification
REQ-030 Reset -> vc_free_o=2'b11, valid_o=0, error_o=0.
REQ-031 Claim VC1, send HEAD,BODY,TAIL vc_id=1 back-to-back, on_off_i=2'b11 -> data_o same three flits cycles 1-3 later, valid_o=1 each, vc_free_o[1]=0 until vc_release_i[1] pulse, then 1.
REQ-032 on_off_i[0]=0 with BODY on active VC0 held 3 cycles -> ready_o=0, valid_o=0; on_off_i[0]->1 -> flit out next cycle, once only.
REQ-033 BODY on IDLE VC0 -> ready_o=0, no valid_o, error_o=1 for one cycle.
REQ-034 vc_claim_i=2'b01 and vc_release_i=2'b01 same cycle with VC0 busy, IDLE -> vc_free_o[0]=0, error_o=0; vc_claim_i=2'b11 -> error_o=1, vc_free_o unchanged.
REQ-035 rst asserted after HEAD on VC1 -> next cycle valid_o=0, VC1 IDLE: following BODY on VC1 flagged error.
